io_2to1: RTL and testbench

IO_2TO1 -- requirements
Module: io_2to1

---
 rtl/io_2to1.sv | 207 ++++++++++++++++++++
 tb/tb_io_2to1.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_2to1.sv
// io_2to1: two four-phase message sources plus one merged-channel sink that
// tracks per-source continuity and flags routing errors.

module io_2to1_src #(
    parameter int unsigned SRC_ID   = 0,
    parameter int unsigned DST_ADDR = 1,
    parameter int unsigned GAP      = 0,
    parameter int unsigned ASZ      = 8,
    parameter int unsigned DSZ      = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    output logic [ASZ-1:0] src,
    output logic [ASZ-1:0] dst,
    output logic [DSZ-1:0] dat,
    output logic           req,
    input  logic           ack
);
    // state  | meaning
    // S_IDLE | wait for ack=0, then load next message and raise req
    // S_REQ  | req=1 until ack=1
    // S_REL  | req=0 until ack=0
    // S_GAP  | spacing: one cycle, plus GAP down-counter ticks
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_GAP} state_t;

    localparam logic [3:0] GAP_LD = 4'(GAP);

    state_t         state, state_nxt;
    logic [3:0]     seq_cnt, seq_cnt_nxt;
    logic [3:0]     gap_cnt, gap_cnt_nxt;
    logic [DSZ-1:0] dat_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            seq_cnt <= '0;
            gap_cnt <= '0;
            dat     <= '0;
        end else begin
            state   <= state_nxt;
            seq_cnt <= seq_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            dat     <= dat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        seq_cnt_nxt = seq_cnt;
        gap_cnt_nxt = gap_cnt;
        dat_nxt     = dat;
        case (state)
            S_IDLE: begin
                // a stale ack (e.g. left over from reset) blocks the next request
                if (!ack) begin
                    dat_nxt     = DSZ'(seq_cnt);
                    seq_cnt_nxt = seq_cnt + 4'd1;
                    state_nxt   = S_REQ;
                end
            end
            S_REQ: begin
                if (ack) state_nxt = S_REL;
            end
            S_REL: begin
                if (!ack) begin
                    state_nxt   = S_GAP;
                    gap_cnt_nxt = GAP_LD;
                end
            end
            S_GAP: begin
                if (gap_cnt == 4'd0) state_nxt = S_IDLE;
                else                 gap_cnt_nxt = gap_cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign req = (state == S_REQ);
    assign src = ASZ'(SRC_ID);
    assign dst = ASZ'(DST_ADDR);
endmodule

module io_2to1_sink #(
    parameter int unsigned SRC_ID_0 = 0,
    parameter int unsigned SRC_ID_1 = 1,
    parameter int unsigned DST_ADDR = 1,
    parameter int unsigned ASZ      = 8,
    parameter int unsigned DSZ      = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [ASZ-1:0] src,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    input  logic           req,
    output logic           ack,
    output logic [DSZ-1:0] ck_dat_0,
    output logic [DSZ-1:0] ck_dat_1,
    output logic [7:0]     cnt_0,
    output logic [7:0]     cnt_1,
    output logic           err_0,
    output logic           err_1,
    output logic           err
);
    localparam logic [ASZ-1:0] ID0    = ASZ'(SRC_ID_0);
    localparam logic [ASZ-1:0] ID1    = ASZ'(SRC_ID_1);
    localparam logic [ASZ-1:0] DST    = ASZ'(DST_ADDR);
    localparam logic [DSZ-1:0] CK_MAX = DSZ'(14);
    localparam logic [DSZ-1:0] D_MAX  = DSZ'(15);

    logic accept, route_ok;

    assign accept   = req && !ack;
    assign route_ok = (dst == DST) && ((src == ID0) || (src == ID1));

    // a checkpoint of 15 or above (reset value, or wrap point) skips continuity
    function automatic logic seq_bad(input logic [DSZ-1:0] ck, input logic [DSZ-1:0] d);
        return (d > D_MAX) || ((ck <= CK_MAX) && ((ck + DSZ'(1)) != d));
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack      <= 1'b0;
            ck_dat_0 <= '1;
            ck_dat_1 <= '1;
            cnt_0    <= '0;
            cnt_1    <= '0;
            err_0    <= 1'b0;
            err_1    <= 1'b0;
            err      <= 1'b0;
        end else if (accept) begin
            ack <= 1'b1;
            if (!route_ok) begin
                err <= 1'b1;
            end else if (src == ID0) begin
                ck_dat_0 <= dat;
                cnt_0    <= cnt_0 + 8'd1;
                if (seq_bad(ck_dat_0, dat)) err_0 <= 1'b1;
            end else begin
                ck_dat_1 <= dat;
                cnt_1    <= cnt_1 + 8'd1;
                if (seq_bad(ck_dat_1, dat)) err_1 <= 1'b1;
            end
        end else if (!req && ack) begin
            ack <= 1'b0;
        end
    end
endmodule

module io_2to1 #(
    parameter int unsigned SRC_ID_0 = 0,
    parameter int unsigned SRC_ID_1 = 1,
    parameter int unsigned DST_ADDR = 1,
    parameter int unsigned GAP_1    = 0,
    parameter int unsigned ASZ      = 8,
    parameter int unsigned DSZ      = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic [ASZ-1:0] o1_src,
    output logic [ASZ-1:0] o1_dst,
    output logic [DSZ-1:0] o1_dat,
    output logic           o1_req,
    input  logic           o1_ack,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic           i0_req,
    output logic           i0_ack,
    output logic [DSZ-1:0] o_0_ck_dat,
    output logic [DSZ-1:0] o_1_ck_dat,
    output logic [7:0]     o_0_cnt,
    output logic [7:0]     o_1_cnt,
    output logic           o_0_err,
    output logic           o_1_err,
    output logic           o_err
);
    io_2to1_src #(
        .SRC_ID(SRC_ID_0), .DST_ADDR(DST_ADDR), .GAP(0), .ASZ(ASZ), .DSZ(DSZ)
    ) u_src_0 (
        .i_clk(i_clk), .i_rst(i_rst),
        .src(o0_src), .dst(o0_dst), .dat(o0_dat), .req(o0_req), .ack(o0_ack)
    );

    io_2to1_src #(
        .SRC_ID(SRC_ID_1), .DST_ADDR(DST_ADDR), .GAP(GAP_1), .ASZ(ASZ), .DSZ(DSZ)
    ) u_src_1 (
        .i_clk(i_clk), .i_rst(i_rst),
        .src(o1_src), .dst(o1_dst), .dat(o1_dat), .req(o1_req), .ack(o1_ack)
    );

    io_2to1_sink #(
        .SRC_ID_0(SRC_ID_0), .SRC_ID_1(SRC_ID_1), .DST_ADDR(DST_ADDR),
        .ASZ(ASZ), .DSZ(DSZ)
    ) u_sink (
        .i_clk(i_clk), .i_rst(i_rst),
        .src(i0_src), .dst(i0_dst), .dat(i0_dat), .req(i0_req), .ack(i0_ack),
        .ck_dat_0(o_0_ck_dat), .ck_dat_1(o_1_ck_dat),
        .cnt_0(o_0_cnt), .cnt_1(o_1_cnt),
        .err_0(o_0_err), .err_1(o_1_err), .err(o_err)
    );
endmodule

// File: tb/tb_io_2to1.sv
// Bench for io_2to1: acts as the 2:1 merger between the two sources and the
// sink, and checks both sides against a message-level reference model.

module tb_io_2to1;
    localparam int ASZ  = 8;
    localparam int DSZ  = 8;
    localparam int ID0  = 0;
    localparam int ID1  = 1;
    localparam int DST  = 1;
    localparam int GAP1 = 5;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [ASZ-1:0] o0_src, o0_dst, o1_src, o1_dst, i0_src, i0_dst;
    logic [DSZ-1:0] o0_dat, o1_dat, i0_dat, o_0_ck_dat, o_1_ck_dat;
    logic           o0_req, o0_ack, o1_req, o1_ack, i0_req, i0_ack;
    logic [7:0]     o_0_cnt, o_1_cnt;
    logic           o_0_err, o_1_err, o_err;

    io_2to1 #(
        .SRC_ID_0(ID0), .SRC_ID_1(ID1), .DST_ADDR(DST), .GAP_1(GAP1),
        .ASZ(ASZ), .DSZ(DSZ)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_req(o0_req), .o0_ack(o0_ack),
        .o1_src(o1_src), .o1_dst(o1_dst), .o1_dat(o1_dat), .o1_req(o1_req), .o1_ack(o1_ack),
        .i0_src(i0_src), .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_req(i0_req), .i0_ack(i0_ack),
        .o_0_ck_dat(o_0_ck_dat), .o_1_ck_dat(o_1_ck_dat),
        .o_0_cnt(o_0_cnt), .o_1_cnt(o_1_cnt),
        .o_0_err(o_0_err), .o_1_err(o_1_err), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // message-level reference model
    int exp_seq[2];
    int m_ck[2];
    int m_cnt[2];
    bit m_err_k[2];
    bit m_err;

    // merger state
    int  ph, sel, rr, delay, done, cyc;
    bit  allow[2];
    bit  rand_arb, drop_armed, bad_dst_next, bad_src_next;
    int  drop_dat;
    logic [ASZ-1:0] cap_src, cap_dst;
    logic [DSZ-1:0] cap_dat;
    bit  ack1_fell;
    int  ack1_fall_cyc;
    logic o1_req_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_seq[k] = 0;
            m_ck[k]    = (1 << DSZ) - 1;
            m_cnt[k]   = 0;
            m_err_k[k] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_accept(input int s, input int d, input int v);
        int k;
        if (d != DST || (s != ID0 && s != ID1)) begin
            m_err = 1;
        end else begin
            k = (s == ID0) ? 0 : 1;
            if (v > 15 || (m_ck[k] <= 14 && m_ck[k] + 1 != v)) m_err_k[k] = 1;
            m_ck[k]  = v;
            m_cnt[k] = (m_cnt[k] + 1) % 256;
        end
    endtask

    function automatic logic src_req(input int k);
        return (k == 0) ? o0_req : o1_req;
    endfunction

    function automatic logic [2*ASZ+DSZ-1:0] src_fields(input int k);
        return (k == 0) ? {o0_src, o0_dst, o0_dat} : {o1_src, o1_dst, o1_dat};
    endfunction

    task automatic set_ack(input int k, input logic v);
        if (k == 0) o0_ack = v;
        else        o1_ack = v;
    endtask

    task automatic check_sink();
        check("cnt0",   o_0_cnt,    m_cnt[0]);
        check("cnt1",   o_1_cnt,    m_cnt[1]);
        check("ckdat0", o_0_ck_dat, m_ck[0]);
        check("ckdat1", o_1_ck_dat, m_ck[1]);
        check("err0",   o_0_err,    m_err_k[0]);
        check("err1",   o_1_err,    m_err_k[1]);
        check("err",    o_err,      m_err);
    endtask

    // one merger cycle: sample and drive on the falling edge
    task automatic tick();
        logic r0, r1;
        @(negedge i_clk);
        cyc++;
        if (ack1_fell && o1_req && !o1_req_q) begin
            check("gap1", ((cyc - ack1_fall_cyc) >= GAP1), 1);
            ack1_fell = 0;
        end
        o1_req_q = o1_req;
        case (ph)
            0: begin
                if (delay > 0) begin
                    delay--;
                end else if (!i0_ack) begin
                    r0 = o0_req && allow[0];
                    r1 = o1_req && allow[1];
                    if (r0 || r1) begin
                        if (r0 && r1) sel = rand_arb ? int'($urandom_range(0, 1)) : rr;
                        else          sel = r0 ? 0 : 1;
                        rr = 1 - sel;
                        {cap_src, cap_dst, cap_dat} = src_fields(sel);
                        check("src_addr", {cap_src, cap_dst}, {8'((sel == 0) ? ID0 : ID1), 8'(DST)});
                        check("src_dat", cap_dat, exp_seq[sel]);
                        exp_seq[sel] = (exp_seq[sel] + 1) % 16;
                        if (sel == 1 && drop_armed && int'(cap_dat) == drop_dat) begin
                            drop_armed = 0;
                            set_ack(sel, 1'b1);
                            ph = 2;
                        end else begin
                            i0_src = bad_src_next ? ASZ'(7) : cap_src;
                            i0_dst = bad_dst_next ? ASZ'(DST + 1) : cap_dst;
                            i0_dat = cap_dat;
                            bad_src_next = 0;
                            bad_dst_next = 0;
                            i0_req = 1'b1;
                            ph = 1;
                        end
                    end
                end
            end
            1: begin
                if (i0_ack) begin
                    model_accept(int'(i0_src), int'(i0_dst), int'(i0_dat));
                    check_sink();
                    check("stable", src_fields(sel), {cap_src, cap_dst, cap_dat});
                    i0_req = 1'b0;
                    set_ack(sel, 1'b1);
                    ph = 2;
                end
            end
            default: begin
                if (!src_req(sel)) begin
                    set_ack(sel, 1'b0);
                    if (sel == 1) begin
                        ack1_fell     = 1;
                        ack1_fall_cyc = cyc;
                    end
                    done++;
                    ph = 0;
                    delay = int'($urandom_range(0, 2));
                end
            end
        endcase
    endtask

    task automatic run(input int n, input string tag);
        int target = done + n;
        int budget = n * 40 + 100;
        while (done < target && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_done"}, (done >= target), 1);
    endtask

    // called right after a falling edge; reset spans exactly one rising edge
    task automatic do_reset(input logic hold_ack0);
        i_rst  = 1'b1;
        i0_req = 1'b0;
        o0_ack = hold_ack0;
        o1_ack = 1'b0;
        ph = 0; delay = 0; ack1_fell = 0;
        @(negedge i_clk);
        cyc++;
        check("rst_o0_req", o0_req, 0);
        check("rst_o1_req", o1_req, 0);
        check("rst_i0_ack", i0_ack, 0);
        check("rst_o0", {o0_src, o0_dst, o0_dat}, {8'(ID0), 8'(DST), 8'd0});
        check("rst_o1", {o1_src, o1_dst, o1_dat}, {8'(ID1), 8'(DST), 8'd0});
        check("rst_ck", {o_0_ck_dat, o_1_ck_dat}, 16'hffff);
        check("rst_cnt", {o_0_cnt, o_1_cnt}, 0);
        check("rst_err", {o_0_err, o_1_err, o_err}, 0);
        model_reset();
        o1_req_q = o1_req;
        i_rst = 1'b0;
    endtask

    initial begin
        int budget;
        i_rst = 1'b1;
        o0_ack = 1'b0; o1_ack = 1'b0;
        i0_req = 1'b0; i0_src = '0; i0_dst = '0; i0_dat = '0;
        ph = 0; sel = 0; rr = 0; delay = 0; done = 0; cyc = 0;
        rand_arb = 0; drop_armed = 0; bad_dst_next = 0; bad_src_next = 0; drop_dat = 0;
        ack1_fell = 0; ack1_fall_cyc = 0; o1_req_q = 1'b0;
        allow = '{1, 1};
        model_reset();
        @(negedge i_clk);
        do_reset(1'b0);

        // only SRC_0 served: data 0..15 then 0..3
        allow = '{1, 0};
        run(20, "src0_only");
        check("src0_only_cnt0", o_0_cnt, 20);
        check("src0_only_ck0",  o_0_ck_dat, 3);
        check("src0_only_cnt1", o_1_cnt, 0);

        // round-robin merger, 100 messages
        do_reset(1'b0);
        allow = '{1, 1};
        run(100, "rr");
        check("rr_sum", 32'(o_0_cnt) + 32'(o_1_cnt), 100);
        check("rr_noerr", {o_0_err, o_1_err, o_err}, 0);

        // routing errors, then random arbitration (skipped data flags continuity)
        bad_dst_next = 1;
        run(1, "bad_dst");
        check("bad_dst_err", o_err, 1);
        check("bad_dst_sum", 32'(o_0_cnt) + 32'(o_1_cnt), 100);
        bad_src_next = 1;
        run(1, "bad_src");
        check("bad_src_sum", 32'(o_0_cnt) + 32'(o_1_cnt), 100);
        rand_arb = 1;
        run(40, "rand");

        // SRC_1 message with data 2 is dropped by the merger
        do_reset(1'b0);
        rand_arb = 0;
        drop_armed = 1;
        drop_dat = 2;
        run(10, "drop");
        check("drop_err1", o_1_err, 1);
        check("drop_err0", o_0_err, 0);

        // reset while SRC_0 has req=1 and ack=1
        allow = '{1, 0};
        budget = 200;
        while (!(ph == 2 && sel == 0 && o0_req && o0_ack) && budget > 0) begin
            tick();
            budget--;
        end
        check("stale_setup", (budget > 0), 1);
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            cyc++;
            check("stale_hold", o0_req, 0);
        end
        o0_ack = 1'b0;
        allow = '{1, 1};
        run(12, "post_stale");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
